// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

  // Serial frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned DATA_BITS            = 8;

endpackage : uart_pkg

// File: rtl/uart_tx_unit_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST);

  // Count within the bit period; restart on clear or after the last cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule : uart_baud_tick

// File: rtl/uart_tx_unit.sv
// Double-buffered UART transmitter: TXREG holding register feeding a frame shifter.
//
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte and tx_en
//   START | driving the start bit (0)
//   DATA  | driving data bits 0..7, LSB first
//   STOP  | driving the stop bit (1); may chain straight into START
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       write_en,
  input  logic       tx_en,
  output logic       tx,
  output logic       TXIF,
  output logic       TRMT
);

  uart_state_t state, state_nxt;
  logic [7:0]  txreg, txreg_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic        tx_r, tx_nxt;
  logic        txif_r, txif_nxt;
  logic        trmt_r, trmt_nxt;
  logic        tick;
  logic        clear;
  logic [2:0]  idx_inc;

  assign tx      = tx_r;
  assign TXIF    = txif_r;
  assign TRMT    = trmt_r;
  assign idx_inc = bit_idx + 3'd1;

  // Every state entry restarts the bit period; IDLE has no bit timing.
  assign clear = (state_nxt != state) || (state == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  // Register FSM state and datapath; reset aborts any frame and drops TXREG.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      txreg   <= 8'h00;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
      tx_r    <= 1'b1;
      txif_r  <= 1'b1;
      trmt_r  <= 1'b1;
    end else begin
      state   <= state_nxt;
      txreg   <= txreg_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      tx_r    <= tx_nxt;
      txif_r  <= txif_nxt;
      trmt_r  <= trmt_nxt;
    end
  end

  // Next-state and datapath decode, including buffer load and frame chaining.
  always_comb begin
    state_nxt   = state;
    txreg_nxt   = txreg;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx_r;
    txif_nxt    = txif_r;
    trmt_nxt    = trmt_r;

    // A write only lands when the buffer is empty. A transfer requires
    // TXIF=0, so a write can never collide with a transfer below.
    if (write_en && txif_r) begin
      txreg_nxt = data_in;
      txif_nxt  = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (!txif_r && tx_en) begin
          shreg_nxt = txreg;
          txif_nxt  = 1'b1;
          trmt_nxt  = 1'b0;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_nxt = 3'd0;
          tx_nxt      = shreg[0];
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = idx_inc;
            tx_nxt      = shreg[idx_inc];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!txif_r && tx_en) begin
            shreg_nxt = txreg;
            txif_nxt  = 1'b1;
            trmt_nxt  = 1'b0;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            trmt_nxt  = 1'b1;
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule : uart_tx_unit

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit with 4 clocks per bit.
module tb_uart_tx_unit;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       write_en;
  logic       tx_en;
  logic       tx;
  logic       TXIF;
  logic       TRMT;

  int checks;
  int failures;

  uart_tx_unit #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .write_en (write_en),
    .tx_en    (tx_en),
    .tx       (tx),
    .TXIF     (TXIF),
    .TRMT     (TRMT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks frame samples first..last; sample 0 is the cycle right after the
  // start-bit edge. write_en is dropped after each edge so a single-cycle
  // write can be set up before calling.
  task automatic frame_check(input logic [7:0] d, input int first, input int last);
    logic exp;
    for (int i = first; i <= last; i++) begin
      if (i < CPB)           exp = 1'b0;
      else if (i >= 9 * CPB) exp = 1'b1;
      else                   exp = d[(i / CPB) - 1];
      chk($sformatf("frame_%02h_s%0d", d, i), {7'd0, tx}, {7'd0, exp});
      step();
      write_en = 1'b0;
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1) lows++;
      step();
    end
    chk(tag, 8'(lows), 8'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    data_in  = 8'h00;
    write_en = 1'b0;
    tx_en    = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_tx",   {7'd0, tx},   8'd1);
    chk("rst_txif", {7'd0, TXIF}, 8'd1);
    chk("rst_trmt", {7'd0, TRMT}, 8'd1);
    rst = 1'b1;
    step();
    chk("idle_tx", {7'd0, tx}, 8'd1);

    // Single byte 0xA5: write on edge N, start bit on edge N+1
    tx_en    = 1'b1;
    data_in  = 8'hA5;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
    chk("a5_wr_txif", {7'd0, TXIF}, 8'd0);
    chk("a5_wr_tx",   {7'd0, tx},   8'd1);
    chk("a5_wr_trmt", {7'd0, TRMT}, 8'd1);
    step();
    chk("a5_xfer_txif", {7'd0, TXIF}, 8'd1);
    chk("a5_xfer_trmt", {7'd0, TRMT}, 8'd0);
    frame_check(8'hA5, 0, 39);
    chk("a5_end_trmt", {7'd0, TRMT}, 8'd1);
    chk("a5_end_tx",   {7'd0, tx},   8'd1);

    // Back-to-back 0x55 then 0x0F, second written while TXIF=1
    data_in  = 8'h55;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
    step();
    chk("b2b_first_start", {7'd0, tx}, 8'd0);
    data_in  = 8'h0F;
    write_en = 1'b1;
    frame_check(8'h55, 0, 0);
    chk("b2b_buffered_txif", {7'd0, TXIF}, 8'd0);
    frame_check(8'h55, 1, 39);
    chk("b2b_no_gap_trmt", {7'd0, TRMT}, 8'd0);
    chk("b2b_no_gap_txif", {7'd0, TXIF}, 8'd1);
    frame_check(8'h0F, 0, 39);
    chk("b2b_end_trmt", {7'd0, TRMT}, 8'd1);

    // Write while full: 0x11 sent, 0x22 buffered, 0x33 dropped
    data_in  = 8'h11;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
    step();
    data_in  = 8'h22;
    write_en = 1'b1;
    frame_check(8'h11, 0, 0);
    chk("full_22_txif", {7'd0, TXIF}, 8'd0);
    data_in  = 8'h33;
    write_en = 1'b1;
    frame_check(8'h11, 1, 39);
    frame_check(8'h22, 0, 39);
    chk("full_end_trmt", {7'd0, TRMT}, 8'd1);
    chk("full_end_txif", {7'd0, TXIF}, 8'd1);
    idle_watch("full_33_never_sent", 50);

    // tx_en gating: byte waits in TXREG until enabled
    tx_en    = 1'b0;
    data_in  = 8'hC3;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
    idle_watch("gate_tx_idle", 6);
    chk("gate_txif", {7'd0, TXIF}, 8'd0);
    chk("gate_trmt", {7'd0, TRMT}, 8'd1);
    tx_en = 1'b1;
    step();
    chk("gate_start_txif", {7'd0, TXIF}, 8'd1);
    chk("gate_start_trmt", {7'd0, TRMT}, 8'd0);
    frame_check(8'hC3, 0, 39);
    chk("gate_end_trmt", {7'd0, TRMT}, 8'd1);

    // Reset during DATA bit 3 with a byte buffered
    data_in  = 8'hF0;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
    step();
    data_in  = 8'h7E;
    write_en = 1'b1;
    frame_check(8'hF0, 0, 17);
    chk("rmid_buffered_txif", {7'd0, TXIF}, 8'd0);
    chk("rmid_bit3_low",      {7'd0, tx},   8'd0);
    rst = 1'b0;
    step();
    chk("rmid_tx",   {7'd0, tx},   8'd1);
    chk("rmid_txif", {7'd0, TXIF}, 8'd1);
    chk("rmid_trmt", {7'd0, TRMT}, 8'd1);
    rst = 1'b1;
    idle_watch("rmid_no_toggle", 50);
    chk("rmid_after_txif", {7'd0, TXIF}, 8'd1);
    chk("rmid_after_trmt", {7'd0, TRMT}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_unit
